// File: rtl/seg_pattern_decoder.sv
// Recovers the hex digit shown on an external 7-segment bus.
// The raw lines are synchronised, then debounced. Each settled pattern is decoded
// and offered once on a valid/ready interface.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   segments_in  - raw segment lines {g,f,e,d,c,b,a}, async to clk
//   value        - decoded digit (0 when err or blank)
//   valid/ready  - report handshake; accepted when both high at a rising edge
//   err          - reported pattern is not a hex glyph
//   blank        - reported pattern has all segments off
//   overrun      - sticky until accept: a new settled pattern was dropped
module seg_pattern_decoder #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter bit          ACTIVE_LOW    = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] segments_in,
   output logic [3:0] value,
   output logic       valid,
   input  logic       ready,
   output logic       err,
   output logic       blank,
   output logic       overrun
);

   localparam int unsigned SEG_W = 7;
   localparam int unsigned VAL_W = 4;
   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [0:0] {IDLE = 1'b0, REPORT = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [SEG_W-1:0]   sync1, sync2, pat, prev, last_rep, last_rep_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               stable_evt;
   logic [VAL_W-1:0]   dec_value, value_nxt;
   logic               dec_err, dec_blank;
   logic               valid_nxt, err_nxt, blank_nxt, overrun_nxt;

   // Two-flop synchroniser per segment line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= segments_in;
         sync2 <= sync1;
      end
   end

   // Normalise to active-high after synchronisation
   assign pat = sync2 ^ {SEG_W{ACTIVE_LOW}};

   // Debounce: restart on any change, saturate once settled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= '0;
         cnt  <= '0;
      end else if (pat != prev) begin
         prev <= pat;
         cnt  <= '0;
      end else if (cnt < CNT_W'(STABLE_CYCLES)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Fires once per settled pattern, on the cycle the count reaches its last step
   assign stable_evt = (cnt == CNT_W'(STABLE_CYCLES - 1)) && (pat == prev);

   // Glyph decode of the debounced pattern
   always_comb begin
      dec_value = '0;
      dec_err   = 1'b0;
      dec_blank = 1'b0;
      case (prev)
         7'h3F:   dec_value = 4'h0;
         7'h06:   dec_value = 4'h1;
         7'h5B:   dec_value = 4'h2;
         7'h4F:   dec_value = 4'h3;
         7'h66:   dec_value = 4'h4;
         7'h6D:   dec_value = 4'h5;
         7'h7D:   dec_value = 4'h6;
         7'h07:   dec_value = 4'h7;
         7'h7F:   dec_value = 4'h8;
         7'h6F:   dec_value = 4'h9;
         7'h77:   dec_value = 4'hA;
         7'h7C:   dec_value = 4'hB;
         7'h39:   dec_value = 4'hC;
         7'h5E:   dec_value = 4'hD;
         7'h79:   dec_value = 4'hE;
         7'h71:   dec_value = 4'hF;
         7'h00:   dec_blank = 1'b1;
         default: dec_err   = 1'b1;
      endcase
   end

   // Report FSM state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_rep <= '0;
         value    <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
         blank    <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_rep <= last_rep_nxt;
         value    <= value_nxt;
         valid    <= valid_nxt;
         err      <= err_nxt;
         blank    <= blank_nxt;
         overrun  <= overrun_nxt;
      end
   end

   // Next-state: report new settled patterns, hold the report until accepted
   always_comb begin
      state_nxt    = state;
      last_rep_nxt = last_rep;
      value_nxt    = value;
      valid_nxt    = valid;
      err_nxt      = err;
      blank_nxt    = blank;
      overrun_nxt  = overrun;
      case (state)
         IDLE: begin
            if (stable_evt && (prev != last_rep)) begin
               value_nxt    = dec_value;
               err_nxt      = dec_err;
               blank_nxt    = dec_blank;
               last_rep_nxt = prev;
               valid_nxt    = 1'b1;
               state_nxt    = REPORT;
            end
         end
         REPORT: begin
            // Accept has priority; a coincident settle event is dropped silently
            if (ready) begin
               valid_nxt   = 1'b0;
               overrun_nxt = 1'b0;
               state_nxt   = IDLE;
            end else if (stable_evt && (prev != last_rep)) begin
               overrun_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
module tb_seg_pattern_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg;
   logic       ready;
   logic [3:0] value;
   logic       valid, err, blank, overrun;

   logic [6:0] seg_al;
   logic       ready_al;
   logic [3:0] value_al;
   logic       valid_al, err_al, blank_al, overrun_al;

   int errors = 0;
   int checks = 0;

   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   always #5 clk = ~clk;

   seg_pattern_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .segments_in(seg), .value(value), .valid(valid),
      .ready(ready), .err(err), .blank(blank), .overrun(overrun));

   seg_pattern_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_n), .segments_in(seg_al), .value(value_al), .valid(valid_al),
      .ready(ready_al), .err(err_al), .blank(blank_al), .overrun(overrun_al));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs n cycles with ready high, counting report cycles and remembering the last value
   task automatic run_count(input int n, output int reps, output logic [3:0] lastv);
      reps  = 0;
      lastv = 4'h0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (valid === 1'b1) begin
            reps++;
            lastv = value;
         end
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      ready    = 1'b0;
      ready_al = 1'b0;
      seg_al   = 7'h7F;
      seg      = 7'h7F;
      for (int i = 0; i < 6; i++) begin
         tick();
         seg = (i % 2 == 0) ? 7'h00 : 7'h7F;
      end
      checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (value !== 4'h0)   begin errors++; $display("FAIL reset_value: got %h expected 0", value); end
      checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if (blank !== 1'b0)   begin errors++; $display("FAIL reset_blank: got %b expected 0", blank); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      seg   = 7'h7F;
      rst_n = 1'b1;
      repeat (6) tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_early_valid: got %b expected 0", valid); end
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b expected 1", valid); end
      checks++; if (value !== 4'h8) begin errors++; $display("FAIL reset_first_value: got %h expected 8", value); end
      ready = 1'b1;
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b expected 0", valid); end
   endtask

   task automatic test_full_table();
      ready = 1'b1;
      for (int g = 0; g < 16; g++) begin
         seg = GLYPH[g];
         repeat (6) tick();
         checks++; if (valid !== 1'b0) begin errors++; $display("FAIL table_early_valid[%0d]: got %b expected 0", g, valid); end
         tick();
         checks++; if (valid !== 1'b1) begin errors++; $display("FAIL table_valid[%0d]: got %b expected 1", g, valid); end
         checks++; if (value !== 4'(g)) begin errors++; $display("FAIL table_value[%0d]: got %h expected %h", g, value, 4'(g)); end
         checks++; if (err !== 1'b0) begin errors++; $display("FAIL table_err[%0d]: got %b expected 0", g, err); end
         repeat (3) tick();
      end
   endtask

   task automatic test_debounce();
      int         reps;
      logic [3:0] lastv;
      ready = 1'b1;
      seg   = 7'h06;
      repeat (3) tick();
      seg = 7'h5B;
      run_count(15, reps, lastv);
      checks++; if (reps !== 1)     begin errors++; $display("FAIL debounce_count: got %0d expected 1", reps); end
      checks++; if (lastv !== 4'h2) begin errors++; $display("FAIL debounce_value: got %h expected 2", lastv); end
      seg = 7'h6D;
      run_count(12, reps, lastv);
      checks++; if (reps !== 1)     begin errors++; $display("FAIL debounce5_count: got %0d expected 1", reps); end
      checks++; if (lastv !== 4'h5) begin errors++; $display("FAIL debounce5_value: got %h expected 5", lastv); end
      seg = 7'h6D;
      run_count(12, reps, lastv);
      checks++; if (reps !== 0) begin errors++; $display("FAIL repeat_count: got %0d expected 0", reps); end
      seg = 7'h7F;
      repeat (2) tick();
      seg = 7'h6D;
      run_count(15, reps, lastv);
      checks++; if (reps !== 0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", reps); end
   endtask

   task automatic test_illegal_blank();
      ready = 1'b0;
      seg   = 7'h55;
      repeat (7) tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL illegal_valid: got %b expected 1", valid); end
      checks++; if (err !== 1'b1)   begin errors++; $display("FAIL illegal_err: got %b expected 1", err); end
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL illegal_value: got %h expected 0", value); end
      checks++; if (blank !== 1'b0) begin errors++; $display("FAIL illegal_blank: got %b expected 0", blank); end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      seg   = 7'h00;
      repeat (7) tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL blank_valid: got %b expected 1", valid); end
      checks++; if (blank !== 1'b1) begin errors++; $display("FAIL blank_blank: got %b expected 1", blank); end
      checks++; if (err !== 1'b0)   begin errors++; $display("FAIL blank_err: got %b expected 0", err); end
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL blank_value: got %h expected 0", value); end
      ready = 1'b1;
      tick();
      seg_al = 7'h40;
      repeat (7) tick();
      checks++; if (valid_al !== 1'b1) begin errors++; $display("FAIL al_valid: got %b expected 1", valid_al); end
      checks++; if (value_al !== 4'h0) begin errors++; $display("FAIL al_value: got %h expected 0", value_al); end
      checks++; if (err_al !== 1'b0)   begin errors++; $display("FAIL al_err: got %b expected 0", err_al); end
      checks++; if (blank_al !== 1'b0) begin errors++; $display("FAIL al_blank: got %b expected 0", blank_al); end
      ready_al = 1'b1;
      tick();
      ready_al = 1'b0;
   endtask

   task automatic test_back_to_back();
      int         reps;
      logic [3:0] lastv;
      ready = 1'b0;
      seg   = 7'h4F;
      repeat (7) tick();
      checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL bp_valid: got %b expected 1", valid); end
      checks++; if (value !== 4'h3)   begin errors++; $display("FAIL bp_value: got %h expected 3", value); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun_clear: got %b expected 0", overrun); end
      seg = 7'h66;
      repeat (10) tick();
      checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", valid); end
      checks++; if (value !== 4'h3)   begin errors++; $display("FAIL bp_hold_value: got %h expected 3", value); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_set: got %b expected 1", overrun); end
      ready = 1'b1;
      tick();
      checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL bp_accept_valid: got %b expected 0", valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_accept_overrun: got %b expected 0", overrun); end
      seg = 7'h00;
      repeat (2) tick();
      seg = 7'h66;
      run_count(15, reps, lastv);
      checks++; if (reps !== 1)     begin errors++; $display("FAIL bp_next_count: got %0d expected 1", reps); end
      checks++; if (lastv !== 4'h4) begin errors++; $display("FAIL bp_next_value: got %h expected 4", lastv); end
   endtask

   task automatic test_reset_in_report();
      int         reps;
      logic [3:0] lastv;
      ready = 1'b0;
      seg   = 7'h07;
      repeat (7) tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rr_valid: got %b expected 1", valid); end
      checks++; if (value !== 4'h7) begin errors++; $display("FAIL rr_value: got %h expected 7", value); end
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rr_async_valid: got %b expected 0", valid); end
      checks++; if (value !== 4'h0) begin errors++; $display("FAIL rr_async_value: got %h expected 0", value); end
      rst_n = 1'b1;
      ready = 1'b1;
      run_count(12, reps, lastv);
      checks++; if (reps !== 1)     begin errors++; $display("FAIL rr_rereport_count: got %0d expected 1", reps); end
      checks++; if (lastv !== 4'h7) begin errors++; $display("FAIL rr_rereport_value: got %h expected 7", lastv); end
   endtask

   initial begin
      test_reset();
      test_full_table();
      test_debounce();
      test_illegal_blank();
      test_back_to_back();
      test_reset_in_report();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
